gpi_event_ctrl: RTL and testbench
=================================

// Module: gpi_event_ctrl
// PURPOSE
//  MMIO slot core that conditions the switch/button inputs and turns them into software events.
//  Each input is synchronised, debounced on a programmable sample tick, and edge-detected.
//  Qualified edges set sticky W1C status bits, and the status bits drive a level interrupt.
//  Sits beside the plain GPI core on the MMIO subsystem and uses the same slot interface.
// PARAMETERS
//  W        16  number of input bits (1..32)
//  PRD_W    20  width of debounce sample-period register (cycles per tick)
//  STABLE   3   consecutive equal ticks required to accept a new level (1..3)
// PORTS
//  clk      in   1      system clock
//  reset    in   1      synchronous, active-high reset
//  cs       in   1      slot chip select
//  read     in   1      read strobe (no side effects; rd_data is address-decoded)
//  write    in   1      write strobe; a register write occurs only when cs&write
//  addr     in   5      register index
//  wr_data  in   32     write data
//  rd_data  out  32     read data, zero-extended
//  din      in   W      raw asynchronous inputs
//  irq      out  1      level interrupt, = |(status & ie)
// BEHAVIOUR
//  Register map (unused bits read 0; unmapped addresses read 0 and ignore writes):
//   0 LEVEL  RO   debounced levels[W-1:0]
//   1 STATUS W1C  sticky edge flags; writing 1 clears the bit, writing 0 leaves it unchanged
//   2 RISE   RW   rising-edge enable per bit
//   3 FALL   RW   falling-edge enable per bit
//   4 IE     RW   interrupt enable per bit
//   5 PERIOD RW   tick period[PRD_W-1:0]; 0 is treated as 1
//  Reset: all registers, sync FFs, counters and debounced levels = 0; PERIOD = 1; irq = 0; rd_data = 0 (addr-decoded).
//  Sync: din passes through 2 FFs (sync) before use.
//  Tick: prescaler counts 0..PERIOD-1 and pulses tick for 1 cycle at wrap. A write to PERIOD clears the prescaler.
//  Debounce (per bit, on tick only): if sync != level, increment cnt; otherwise clear cnt.
//   When cnt reaches STABLE, level <= sync and cnt <= 0.
//   Latency from a stable din change to the LEVEL update = 2 cycles + STABLE ticks (+ prescaler phase).
//  Edge: rise = level_next & ~level; fall = ~level_next & level; both are evaluated in the cycle level updates.
//   status[i] sets on (rise[i]&RISE[i]) | (fall[i]&FALL[i]).
//   Set has priority over a W1C clear of the same bit in the same cycle.
//  irq is registered: it reflects status/IE one cycle after they change.
//  Changing RISE/FALL/IE does not alter existing status bits.
//  Bits >= W of every register: write ignored, read 0.
//  A glitch shorter than STABLE ticks never changes LEVEL or STATUS.
//  Reset mid-debounce discards all counts; no edge is reported for the reset transition.
// TESTING
//  1 Reset: PERIOD=4, all din=0 -> every register reads its reset value; irq=0.
//  2 Debounce: PERIOD=4, RISE=1, IE=1, din[0] 0->1 held -> LEVEL[0]=1 in <= 2+3*4+4 cycles;
//    STATUS=0x1 and irq=1 one cycle later.
//  3 Glitch: din[3] high for 6 cycles with PERIOD=4 -> LEVEL and STATUS stay 0.
//  4 W1C race: write STATUS=0x1 in the same cycle a new rise on bit0 sets it -> STATUS[0] stays 1.
//    A later clear with no edge gives STATUS=0 and irq=0.
//  5 Masking: FALL=0x8, RISE=0, din[3] 1->0 -> STATUS=0x8.
//    With IE=0, irq=0; then writing IE=0x8 gives irq=1 the next cycle.
//  6 Range: W=16, write 0xFFFF_FFFF to RISE -> read 0x0000_FFFF; read addr 7 -> 0.

Source files
------------

// File: rtl/gpi_event_ctrl.sv
// -----------------------------------------------------------------------------
// gpi_event_ctrl
//   MMIO slot core that conditions switch/button inputs into software events.
//   Each input bit is synchronised through two flops, debounced on a
//   programmable sample tick and edge-detected. Qualified edges set sticky
//   write-1-to-clear status bits, which drive a registered level interrupt.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   cs       slot chip select
//   read     read strobe (reads have no side effects; rd_data is addr-decoded)
//   write    write strobe; a register write happens only when cs & write
//   addr     register index (0 LEVEL, 1 STATUS, 2 RISE, 3 FALL, 4 IE, 5 PERIOD)
//   wr_data  write data
//   rd_data  read data, zero-extended; unmapped addresses read 0
//   din      raw asynchronous inputs
//   irq      level interrupt, registered |(status & ie)
// -----------------------------------------------------------------------------
module gpi_event_ctrl #(
   parameter int W      = 16,
   parameter int PRD_W  = 20,
   parameter int STABLE = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [4:0]    addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   input  logic [W-1:0]  din,
   output logic          irq
);

   localparam logic [4:0]       A_LEVEL  = 5'd0;
   localparam logic [4:0]       A_STATUS = 5'd1;
   localparam logic [4:0]       A_RISE   = 5'd2;
   localparam logic [4:0]       A_FALL   = 5'd3;
   localparam logic [4:0]       A_IE     = 5'd4;
   localparam logic [4:0]       A_PERIOD = 5'd5;
   localparam logic [PRD_W-1:0] PRD_ONE  = PRD_W'(1);
   localparam logic [1:0]       STABLE_C = 2'(STABLE);

   // Read strobe has no side effects; upper write-data bits beyond the
   // register widths are intentionally dropped.
   logic unused_bits;
   assign unused_bits = ^{read, wr_data};

   logic             wr_en;
   logic [W-1:0]     sync_p0, sync_p1;
   logic [W-1:0]     level, level_next;
   logic [1:0]       cnt      [W];
   logic [1:0]       cnt_next [W];
   logic [W-1:0]     status, status_next;
   logic [W-1:0]     rise_en, fall_en, ie;
   logic [W-1:0]     rise, fall, set_bits, clr_bits;
   logic [PRD_W-1:0] period, period_eff, pre_cnt;
   logic             tick;

   assign wr_en = cs & write;

   // ---- stage p0/p1: two-flop synchroniser on the raw inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
      end
   end

   // ---- sample tick: prescaler counts 0..period_eff-1, pulses at wrap
   // A PERIOD of 0 behaves like 1 so the tick never stalls.
   assign period_eff = (period == '0) ? PRD_ONE : period;
   assign tick       = (pre_cnt == period_eff - PRD_ONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (wr_en && addr == A_PERIOD) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRD_ONE;
      end
   end

   // ---- debounce: STABLE consecutive mismatching ticks accept the new level
   always_comb begin
      level_next = level;
      for (int i = 0; i < W; i++) begin
         cnt_next[i] = cnt[i];
         if (tick) begin
            if (sync_p1[i] != level[i]) begin
               if (cnt[i] + 2'd1 == STABLE_C) begin
                  level_next[i] = sync_p1[i];
                  cnt_next[i]   = 2'd0;
               end else begin
                  cnt_next[i]   = cnt[i] + 2'd1;
               end
            end else begin
               cnt_next[i] = 2'd0;
            end
         end
      end
   end

   // ---- edge qualification and sticky status
   // A set in the same cycle as a W1C of the same bit wins, so no edge is lost.
   assign rise        = level_next & ~level;
   assign fall        = ~level_next & level;
   assign set_bits    = (rise & rise_en) | (fall & fall_en);
   assign clr_bits    = (wr_en && addr == A_STATUS) ? wr_data[W-1:0] : '0;
   assign status_next = (status & ~clr_bits) | set_bits;

   always_ff @(posedge clk) begin
      if (reset) begin
         level  <= '0;
         status <= '0;
         for (int i = 0; i < W; i++) cnt[i] <= 2'd0;
      end else begin
         level  <= level_next;
         status <= status_next;
         for (int i = 0; i < W; i++) cnt[i] <= cnt_next[i];
      end
   end

   // ---- configuration registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rise_en <= '0;
         fall_en <= '0;
         ie      <= '0;
         period  <= PRD_ONE;
      end else if (wr_en) begin
         case (addr)
            A_RISE:   rise_en <= wr_data[W-1:0];
            A_FALL:   fall_en <= wr_data[W-1:0];
            A_IE:     ie      <= wr_data[W-1:0];
            A_PERIOD: period  <= wr_data[PRD_W-1:0];
            default:  ;
         endcase
      end
   end

   // ---- interrupt: registered, follows status/ie one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= |(status & ie);
      end
   end

   // ---- read decode (combinational, zero-extended)
   always_comb begin
      rd_data = '0;
      case (addr)
         A_LEVEL:  rd_data[W-1:0]     = level;
         A_STATUS: rd_data[W-1:0]     = status;
         A_RISE:   rd_data[W-1:0]     = rise_en;
         A_FALL:   rd_data[W-1:0]     = fall_en;
         A_IE:     rd_data[W-1:0]     = ie;
         A_PERIOD: rd_data[PRD_W-1:0] = period;
         default:  rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_gpi_event_ctrl.sv
module tb_gpi_event_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic [15:0] din = '0;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   gpi_event_ctrl #(.W(16), .PRD_W(20), .STABLE(3)) dut (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .din(din), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wr_data = d; cs = 1'b1; write = 1'b1;
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; cs = 1'b1; read = 1'b1;
      #1;
      d = rd_data;
      cs = 1'b0; read = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d, e;
      logic [31:0] rst_vals [6];
      rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      bus_wr(5'd5, 32'd4);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int a = 0; a < 6; a++) begin
         exp_q.push_back(rst_vals[a]);
         bus_rd(5'(a), d);
         e = exp_q.pop_front();
         checks++;
         if (d !== e) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h expected %h", a, d, e);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_debounce();
      logic [31:0] d;
      logic        irq_at_level;
      int          cycles;
      bit          found;
      bus_wr(5'd2, 32'h1);
      bus_wr(5'd4, 32'h1);
      bus_wr(5'd5, 32'd4);
      @(negedge clk);
      din[0] = 1'b1;
      cycles = 0; found = 0; irq_at_level = 1'bx;
      for (int i = 0; i < 30 && !found; i++) begin
         bus_rd(5'd0, d);
         cycles++;
         if (d[0] === 1'b1) begin
            found = 1;
            irq_at_level = irq;
         end
      end
      checks++;
      if (!found || cycles > 18) begin
         errors++;
         $display("FAIL debounce_latency: found=%0d cycles=%0d expected <= 18", found, cycles);
      end
      checks++;
      if (irq_at_level !== 1'b0) begin
         errors++;
         $display("FAIL debounce_irq_registered: got %b expected 0", irq_at_level);
      end
      bus_rd(5'd1, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL debounce_status: got %h expected 00000001", d);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL debounce_irq: got %b expected 1", irq);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      bus_wr(5'd1, 32'hFFFF);
      bus_wr(5'd2, 32'hFFFF);
      bus_wr(5'd3, 32'hFFFF);
      @(negedge clk);
      din[3] = 1'b1;
      repeat (6) @(negedge clk);
      din[3] = 1'b0;
      repeat (30) @(negedge clk);
      bus_rd(5'd0, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL glitch_level: got %h expected 00000001", d);
      end
      bus_rd(5'd1, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL glitch_status: got %h expected 00000000", d);
      end
   endtask

   task automatic test_w1c_race();
      logic [31:0] d;
      bit          found;
      @(negedge clk);
      din[0] = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         bus_rd(5'd0, d);
         if (d[0] === 1'b0) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL race_fall_wait: level bit0 got %b expected 0", d[0]);
      end
      bus_wr(5'd1, 32'hFFFF);
      bus_rd(5'd1, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL race_pre_clear: got %h expected 00000000", d);
      end
      // PERIOD=1 makes the tick continuous so the level update lands exactly
      // four clocks after this write.
      @(negedge clk);
      addr = 5'd5; wr_data = 32'd1; cs = 1'b1; write = 1'b1;
      din[0] = 1'b1;
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      addr = 5'd1;
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
         errors++;
         $display("FAIL race_before_edge: got %h expected 00000000", rd_data);
      end
      wr_data = 32'h1; cs = 1'b1; write = 1'b1;
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
      #1;
      checks++;
      if (rd_data !== 32'h1) begin
         errors++;
         $display("FAIL race_set_wins: got %h expected 00000001", rd_data);
      end
      bus_wr(5'd1, 32'h1);
      bus_rd(5'd1, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL race_later_clear: got %h expected 00000000", d);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL race_irq_clear: got %b expected 0", irq);
      end
   endtask

   task automatic test_masking();
      logic [31:0] d;
      bit          found;
      bus_wr(5'd4, 32'h0);
      bus_wr(5'd2, 32'h0);
      bus_wr(5'd3, 32'h8);
      @(negedge clk);
      din[3] = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         bus_rd(5'd0, d);
         if (d[3] === 1'b1) found = 1;
      end
      bus_rd(5'd1, d);
      checks++;
      if (!found || d !== 32'h0) begin
         errors++;
         $display("FAIL mask_rise_off: found=%0d status got %h expected 00000000", found, d);
      end
      @(negedge clk);
      din[3] = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         bus_rd(5'd0, d);
         if (d[3] === 1'b0) found = 1;
      end
      bus_rd(5'd1, d);
      checks++;
      if (!found || d !== 32'h8) begin
         errors++;
         $display("FAIL mask_fall_status: found=%0d status got %h expected 00000008", found, d);
      end
      @(negedge clk);
      #1;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL mask_irq_ie0: got %b expected 0", irq);
      end
      @(negedge clk);
      addr = 5'd4; wr_data = 32'h8; cs = 1'b1; write = 1'b1;
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
      #1;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL mask_irq_same_cycle: got %b expected 0", irq);
      end
      @(negedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL mask_irq_next_cycle: got %b expected 1", irq);
      end
   endtask

   task automatic test_range();
      logic [31:0] d, e;
      bus_wr(5'd2, 32'hFFFF_FFFF);
      exp_q.push_back(32'h0000_FFFF);
      bus_rd(5'd2, d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL range_rise: got %h expected %h", d, e);
      end
      bus_wr(5'd5, 32'hFFFF_FFFF);
      exp_q.push_back(32'h000F_FFFF);
      bus_rd(5'd5, d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL range_period: got %h expected %h", d, e);
      end
      bus_wr(5'd7, 32'h1234_5678);
      exp_q.push_back(32'h0);
      bus_rd(5'd7, d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL range_addr7: got %h expected %h", d, e);
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_w1c_race();
      test_masking();
      test_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
